// File: rtl/ex_div_ctrl.sv
// Multi-cycle radix-2 restoring divide sequencer for DIV/DIVU beside the EX-stage ALU.
// Optional DIV_EARLY_EXIT_EN: zero-dividend shortcut plus leading-zero skip of the dividend.
module ex_div_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq_o
);
    // Handshake: start_i is held by EX until ready_o; the result is valid only
    // while ready_o=1, and dropping start_i returns the block to IDLE next edge.
    typedef enum logic [1:0] {S_IDLE, S_ZERO, S_ON, S_END} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W);

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [DATA_W-1:0]   rem, rem_n, quo, quo_n, dvs, dvs_n;
    logic                neg_q, neg_q_n, neg_r, neg_r_n;
    logic                ready_n;
    logic [2*DATA_W-1:0] result_n;
    logic [DATA_W:0]     trial;
    logic [DATA_W-1:0]   mag1, mag2, rem_fix, quo_fix;
    logic                zero_path;

    // Magnitudes wrap at DATA_W bits, so -(min int) stays at the min-int pattern.
    assign mag1    = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign mag2    = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    assign trial   = {rem, quo[DATA_W-1]} - {1'b0, dvs};
    assign rem_fix = neg_r ? -rem : rem;
    assign quo_fix = neg_q ? -quo : quo;

`ifdef DIV_EARLY_EXIT_EN
    assign zero_path = (opdata2_i == '0) || (opdata1_i == '0);

    function automatic logic [CNT_W-1:0] lead_zeros(input logic [DATA_W-1:0] v);
        logic [CNT_W-1:0] n;
        logic             hit;
        n   = '0;
        hit = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (v[i]) hit = 1'b1;
            else if (!hit) n = n + 1'b1;
        end
        return n;
    endfunction
`else
    assign zero_path = (opdata2_i == '0);
`endif

    assign stallreq_o = start_i & ~ready_o & ~annul_i;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rem_n    = rem;
        quo_n    = quo;
        dvs_n    = dvs;
        neg_q_n  = neg_q;
        neg_r_n  = neg_r;
        ready_n  = ready_o;
        result_n = result_o;
        if (annul_i) begin
            state_n  = S_IDLE;
            cnt_n    = '0;
            ready_n  = 1'b0;
            result_n = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        if (zero_path) begin
                            state_n = S_ZERO;
                        end else begin
                            rem_n   = '0;
                            quo_n   = mag1;
                            dvs_n   = mag2;
                            neg_q_n = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                            neg_r_n = signed_div_i & opdata1_i[DATA_W-1];
                            cnt_n   = '0;
                            state_n = S_ON;
                        end
                    end
                end
                S_ZERO: begin
                    result_n = '0;
                    state_n  = S_END;
                end
                S_ON: begin
                    if (cnt == LAST) begin
                        result_n = {rem_fix, quo_fix};
                        ready_n  = 1'b1;
                        state_n  = S_END;
`ifdef DIV_EARLY_EXIT_EN
                    // Leading zero dividend bits only shift through with rem=0; skip them at once.
                    end else if (cnt == '0 && !quo[DATA_W-1]) begin
                        quo_n = quo << lead_zeros(quo);
                        cnt_n = lead_zeros(quo);
`endif
                    end else begin
                        if (!trial[DATA_W]) begin
                            rem_n = trial[DATA_W-1:0];
                            quo_n = {quo[DATA_W-2:0], 1'b1};
                        end else begin
                            rem_n = {rem[DATA_W-2:0], quo[DATA_W-1]};
                            quo_n = {quo[DATA_W-2:0], 1'b0};
                        end
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_END: begin
                    if (start_i) begin
                        ready_n = 1'b1;
                    end else begin
                        state_n  = S_IDLE;
                        ready_n  = 1'b0;
                        result_n = '0;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            ready_o  <= 1'b0;
            result_o <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            rem      <= rem_n;
            quo      <= quo_n;
            dvs      <= dvs_n;
            neg_q    <= neg_q_n;
            neg_r    <= neg_r_n;
            ready_o  <= ready_n;
            result_o <= result_n;
        end
    end
endmodule
